// File: rtl/imem_program_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
package imem_program_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;
  localparam int BANK_WORDS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX_HI = 3'd1,
    RX_LO = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input, IMEM write port and status outputs of the loader.
interface imem_program_loader_if;
  import imem_program_loader_pkg::*;

  logic              START;
  logic              BYTE_VALID;
  logic [BYTE_W-1:0] BYTE_DATA;
  logic              BYTE_READY;
  logic [WORD_W-1:0] IMEM_DATA;
  logic [3:0]        WRITE_SELECT;
  logic              WRITE_ENABLE_LOW;
  logic              WRITE_ENABLE_HIGH;
  logic              CPU_HOLD;
  logic              LOAD_DONE;
  logic              LOAD_ERROR;
  logic [5:0]        WORD_COUNT;

  modport master (
    output START, BYTE_VALID, BYTE_DATA,
    input  BYTE_READY, IMEM_DATA, WRITE_SELECT, WRITE_ENABLE_LOW, WRITE_ENABLE_HIGH,
    input  CPU_HOLD, LOAD_DONE, LOAD_ERROR, WORD_COUNT
  );

  modport slave (
    input  START, BYTE_VALID, BYTE_DATA,
    output BYTE_READY, IMEM_DATA, WRITE_SELECT, WRITE_ENABLE_LOW, WRITE_ENABLE_HIGH,
    output CPU_HOLD, LOAD_DONE, LOAD_ERROR, WORD_COUNT
  );

endinterface

// File: rtl/imem_program_loader_byte_assembler.sv
// Builds a 16-bit word from a high/low byte pair and keeps a running XOR of every byte captured.
module imem_byte_assembler
  import imem_program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cap_hi,
  input  logic              cap_lo,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Capture the addressed byte half and fold it into the checksum.
  always_comb begin
    word_d = word_q;
    csum_d = csum_q;
    if (clear) begin
      word_d = '0;
      csum_d = '0;
    end else if (cap_hi) begin
      word_d[WORD_W-1:BYTE_W] = byte_in;
      csum_d                  = csum_q ^ byte_in;
    end else if (cap_lo) begin
      word_d[BYTE_W-1:0] = byte_in;
      csum_d             = csum_q ^ byte_in;
    end
  end

  // Word and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      csum_q <= '0;
    end else begin
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word = word_q;
  assign csum = csum_q;

endmodule

// File: rtl/imem_program_loader.sv
// Loads a program image from a byte stream into the two IMEM banks and checks its XOR checksum.
//  state | meaning
//  IDLE  | waiting for START, CPU free
//  RX_HI | waiting for high byte of current word
//  RX_LO | waiting for low byte of current word
//  WRITE | one-cycle strobe into the bank selected by addr msb
//  CHECK | waiting for checksum byte
//  DONE  | image loaded and checksum matched, CPU released
//  ERROR | checksum mismatch, CPU kept held
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int NUM_WORDS  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic CLOCK,
  input  logic RESET,
  imem_program_loader_if.slave bus
);

  localparam int SEL_W = $clog2(BANK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [5:0]            count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  we_lo_q, we_lo_d;
  logic                  we_hi_q, we_hi_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  clear, cap_hi, cap_lo, xfer;
  logic [WORD_W-1:0]     word;
  logic [BYTE_W-1:0]     csum;

  assign xfer = bus.BYTE_VALID & ready_q;

  imem_byte_assembler u_asm (
    .clk     (CLOCK),
    .rst     (RESET),
    .clear   (clear),
    .cap_hi  (cap_hi),
    .cap_lo  (cap_lo),
    .byte_in (bus.BYTE_DATA),
    .word    (word),
    .csum    (csum)
  );

  // Next state, address/count updates, and the registered output values for the next state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    clear   = 1'b0;
    cap_hi  = 1'b0;
    cap_lo  = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.START) begin
          state_d = RX_HI;
          addr_d  = '0;
          count_d = '0;
          clear   = 1'b1;
        end
      end
      RX_HI: begin
        if (xfer) begin
          cap_hi  = 1'b1;
          state_d = RX_LO;
        end
      end
      RX_LO: begin
        if (xfer) begin
          cap_lo  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 6'd1;
        state_d = (addr_q == LAST_ADDR) ? CHECK : RX_HI;
      end
      CHECK: begin
        if (xfer) state_d = (bus.BYTE_DATA == csum) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase

    // addr_d equals the write address whenever state_d is WRITE, since addr only moves on leaving WRITE.
    ready_d = (state_d == RX_HI) || (state_d == RX_LO) || (state_d == CHECK);
    we_lo_d = (state_d == WRITE) && !addr_d[ADDR_WIDTH-1];
    we_hi_d = (state_d == WRITE) &&  addr_d[ADDR_WIDTH-1];
    hold_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERROR);
  end

  // State, counters and output registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      we_lo_q <= 1'b0;
      we_hi_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ready_q <= ready_d;
      we_lo_q <= we_lo_d;
      we_hi_q <= we_hi_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.BYTE_READY        = ready_q;
  assign bus.IMEM_DATA         = word;
  assign bus.WRITE_SELECT      = addr_q[SEL_W-1:0];
  assign bus.WRITE_ENABLE_LOW  = we_lo_q;
  assign bus.WRITE_ENABLE_HIGH = we_hi_q;
  assign bus.CPU_HOLD          = hold_q;
  assign bus.LOAD_DONE         = done_q;
  assign bus.LOAD_ERROR        = err_q;
  assign bus.WORD_COUNT        = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for the program loader: a 32-word and a 16-word instance share one stimulus driver.
module tb_imem_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] data;
  logic       dsel;

  always #5 clk = ~clk;

  imem_program_loader_if if32 ();
  imem_program_loader_if if16 ();

  assign if32.START      = start & ~dsel;
  assign if32.BYTE_VALID = valid & ~dsel;
  assign if32.BYTE_DATA  = data;
  assign if16.START      = start & dsel;
  assign if16.BYTE_VALID = valid & dsel;
  assign if16.BYTE_DATA  = data;

  imem_program_loader #(.NUM_WORDS(32), .ADDR_WIDTH(5)) u_dut32 (.CLOCK(clk), .RESET(rst), .bus(if32));
  imem_program_loader #(.NUM_WORDS(16), .ADDR_WIDTH(5)) u_dut16 (.CLOCK(clk), .RESET(rst), .bus(if16));

  logic        ready_o, we_lo_o, we_hi_o, hold_o, done_o, err_o;
  logic [15:0] data_o;
  logic [3:0]  sel_o;
  logic [5:0]  wc_o;

  assign ready_o = dsel ? if16.BYTE_READY        : if32.BYTE_READY;
  assign data_o  = dsel ? if16.IMEM_DATA         : if32.IMEM_DATA;
  assign sel_o   = dsel ? if16.WRITE_SELECT      : if32.WRITE_SELECT;
  assign we_lo_o = dsel ? if16.WRITE_ENABLE_LOW  : if32.WRITE_ENABLE_LOW;
  assign we_hi_o = dsel ? if16.WRITE_ENABLE_HIGH : if32.WRITE_ENABLE_HIGH;
  assign hold_o  = dsel ? if16.CPU_HOLD          : if32.CPU_HOLD;
  assign done_o  = dsel ? if16.LOAD_DONE         : if32.LOAD_DONE;
  assign err_o   = dsel ? if16.LOAD_ERROR        : if32.LOAD_ERROR;
  assign wc_o    = dsel ? if16.WORD_COUNT        : if32.WORD_COUNT;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        hi;
    logic [3:0]  sel;
    logic [15:0] data;
  } wr_t;

  wr_t obs_q[$];
  int  hi_strobes;

  // Record every bank write seen on the selected instance.
  always @(negedge clk) begin
    if (!rst && (we_lo_o || we_hi_o)) begin
      chk("one_strobe", {31'd0, we_lo_o & we_hi_o}, 32'd0);
      obs_q.push_back('{hi: we_hi_o, sel: sel_o, data: data_o});
      if (we_hi_o) hi_strobes++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_o}, 0);
    chk({tag, "_data"},  {16'd0, data_o},  0);
    chk({tag, "_sel"},   {28'd0, sel_o},   0);
    chk({tag, "_we_lo"}, {31'd0, we_lo_o}, 0);
    chk({tag, "_we_hi"}, {31'd0, we_hi_o}, 0);
    chk({tag, "_hold"},  {31'd0, hold_o},  0);
    chk({tag, "_done"},  {31'd0, done_o},  0);
    chk({tag, "_err"},   {31'd0, err_o},   0);
    chk({tag, "_wc"},    {26'd0, wc_o},    0);
  endtask

  // Drive one image: START, then high/low bytes per word and the checksum byte.
  task automatic run_load(input logic [15:0] words[$], input bit corrupt, input int gap_pct,
                          input int glitch_idx, input int abort_idx,
                          output int cyc, output bit timed_out);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    int         idx;
    bit         pulsed, finished, xfer;
    cs = 8'h00;
    foreach (words[k]) begin
      bytes.push_back(words[k][15:8]);
      bytes.push_back(words[k][7:0]);
      cs = cs ^ words[k][15:8] ^ words[k][7:0];
    end
    bytes.push_back(corrupt ? (cs ^ 8'h01) : cs);
    obs_q.delete();
    hi_strobes = 0;
    timed_out  = 0;
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 0;
    idx      = 0;
    pulsed   = 0;
    finished = 0;
    while (!finished) begin
      if (abort_idx >= 0 && idx == abort_idx) begin
        finished = 1;
      end else begin
        start = 1'b0;
        if (idx == glitch_idx && !pulsed && ready_o) begin
          chk("wc_at_glitch", {26'd0, wc_o}, 32'd7);
          start  = 1'b1;
          pulsed = 1;
        end
        valid = (idx < bytes.size()) ? ($urandom_range(99) >= 32'(gap_pct)) : 1'b0;
        data  = valid ? bytes[idx] : 8'($urandom);
        xfer  = valid && ready_o;
        @(negedge clk);
        cyc++;
        if (xfer) idx++;
        if (done_o || err_o) finished = 1;
        if (cyc > 3000) begin
          timed_out = 1;
          finished  = 1;
        end
      end
    end
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_image(input string tag, input logic [15:0] words[$], input bit exp_err);
    chk({tag, "_done"}, {31'd0, done_o}, {31'd0, !exp_err});
    chk({tag, "_err"},  {31'd0, err_o},  {31'd0, exp_err});
    chk({tag, "_hold"}, {31'd0, hold_o}, {31'd0, exp_err});
    chk({tag, "_wc"},   {26'd0, wc_o},   32'(words.size()));
    chk({tag, "_nwr"},  32'(obs_q.size()), 32'(words.size()));
    foreach (words[k]) begin
      wr_t e;
      e.hi   = (k >= 16);
      e.sel  = 4'(k % 16);
      e.data = words[k];
      if (k < obs_q.size()) chk({tag, "_wr"}, 32'(obs_q[k]), 32'(e));
    end
  endtask

  initial begin
    logic [15:0] img[$];
    int          cyc;
    bit          to;

    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    dsel  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst32");
    dsel = 1'b1;
    #1 check_idle_outputs("rst16");
    dsel = 1'b0;

    // Full 32-word image, no source stalls.
    img.delete();
    for (int k = 0; k < 32; k++) img.push_back(16'hA000 + 16'(k));
    run_load(img, 0, 0, -1, -1, cyc, to);
    chk("full_timeout", {31'd0, to}, 0);
    chk("full_latency", 32'(cyc), 32'd97);
    check_image("full", img, 0);

    // Corrupted checksum, then a good random image.
    run_load(img, 1, 0, -1, -1, cyc, to);
    chk("bad_timeout", {31'd0, to}, 0);
    check_image("bad", img, 1);
    repeat (4) @(negedge clk);
    chk("bad_hold_stays", {31'd0, hold_o}, 1);
    chk("bad_err_stays",  {31'd0, err_o},  1);
    img.delete();
    for (int k = 0; k < 32; k++) img.push_back(16'($urandom));
    run_load(img, 0, 0, -1, -1, cyc, to);
    chk("reload_timeout", {31'd0, to}, 0);
    check_image("reload", img, 0);

    // Random source stalls.
    img.delete();
    for (int k = 0; k < 32; k++) img.push_back(16'($urandom));
    run_load(img, 0, 50, -1, -1, cyc, to);
    chk("gap_timeout", {31'd0, to}, 0);
    chk("gap_latency_min", {31'd0, cyc >= 97}, 1);
    check_image("gap", img, 0);

    // START pulsed in RX_HI of word 7 must be ignored.
    img.delete();
    for (int k = 0; k < 32; k++) img.push_back(16'($urandom));
    run_load(img, 0, 30, 14, -1, cyc, to);
    chk("glitch_timeout", {31'd0, to}, 0);
    check_image("glitch", img, 0);

    // Reset while waiting for the low byte of word 5.
    run_load(img, 0, 0, -1, 11, cyc, to);
    chk("abort_wc",    {26'd0, wc_o},    32'd5);
    chk("abort_ready", {31'd0, ready_o}, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_ready", {31'd0, ready_o}, 0);
    chk("abort_idle_hold",  {31'd0, hold_o},  0);

    // 16-word instance: low bank only.
    dsel = 1'b1;
    img.delete();
    for (int k = 1; k <= 16; k++) img.push_back(16'(k));
    run_load(img, 0, 0, -1, -1, cyc, to);
    chk("n16_timeout", {31'd0, to}, 0);
    chk("n16_latency", 32'(cyc), 32'd49);
    chk("n16_no_high", 32'(hi_strobes), 0);
    check_image("n16", img, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
